// File: rtl/video_pattern_gen_if.sv
// Pixel stream bundle: data, strobe, line start, frame start.
// The generator drives it (master); the downstream scaler listens (slave).
interface video_pattern_gen_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic [PIXEL_WIDTH-1:0] do_o;
    logic                   de_o;
    logic                   hs_o;
    logic                   vs_o;

    modport master (output do_o, de_o, hs_o, vs_o);
    modport slave  (input  do_o, de_o, hs_o, vs_o);
endinterface

// File: rtl/video_pattern_gen.sv
// Paced test-pattern video source with programmable geometry.
// Config is shadowed at every frame start; frames are never cut short.
module video_pattern_gen #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int CNT_WIDTH    = 12,
    parameter int PERIOD_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [PERIOD_WIDTH-1:0] pix_period_i,
    input  logic [CNT_WIDTH-1:0]    line_width_i,
    input  logic [CNT_WIDTH-1:0]    frame_height_i,
    input  logic [2:0]              pattern_i,
    input  logic [PIXEL_WIDTH-1:0]  pattern_arg_i,
    video_pattern_gen_if.master     vid,
    output logic                    busy_o,
    output logic [15:0]             frame_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Shadow config, stored as "limit minus one" so compares are direct.
    logic [PERIOD_WIDTH-1:0] pm1_q, pm1_d;
    logic [CNT_WIDTH-1:0]    wm1_q, wm1_d;
    logic [CNT_WIDTH-1:0]    hm1_q, hm1_d;
    logic [2:0]              pat_q, pat_d;
    logic [PIXEL_WIDTH-1:0]  arg_q, arg_d;

    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]    x_q, x_d;
    logic [CNT_WIDTH-1:0]    y_q, y_d;

    logic [PIXEL_WIDTH-1:0]  do_q, do_d;
    logic                    de_q, de_d;
    logic                    hs_q, hs_d;
    logic                    vs_q, vs_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [15:0]             fcnt_q, fcnt_d;

    logic [PIXEL_WIDTH-1:0]  pix;
    logic [CNT_WIDTH-1:0]    x_shr;

    // Pattern value for the pixel at the current (x,y).
    always_comb begin
        pix   = '0;
        x_shr = x_q >> arg_q[3:0];
        unique case (pat_q)
            3'd0: pix = PIXEL_WIDTH'(x_q);
            3'd1: pix = PIXEL_WIDTH'(y_q);
            3'd2: pix = (x_q == CNT_WIDTH'(arg_q)) ? '1 : '0;
            3'd3: pix = x_shr[0] ? '0 : '1;
            3'd4: pix = (x_q == y_q) ? '1 : '0;
            3'd5: pix = arg_q;
            default: pix = '0;
        endcase
    end

    // Next-state: pixel pacing, raster walk, frame wrap and config latch.
    always_comb begin
        state_d = state_q;
        pm1_d   = pm1_q;
        wm1_d   = wm1_q;
        hm1_d   = hm1_q;
        pat_d   = pat_q;
        arg_d   = arg_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        do_d    = do_q;
        de_d    = 1'b0;
        hs_d    = 1'b0;
        vs_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        fcnt_d  = done_q ? fcnt_q + 16'd1 : fcnt_q;

        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == pm1_q) begin
                    cnt_d = '0;
                    de_d  = 1'b1;
                    hs_d  = (x_q == '0);
                    vs_d  = (x_q == '0) && (y_q == '0);
                    do_d  = pix;
                    if (x_q == wm1_q) begin
                        x_d = '0;
                        if (y_q == hm1_q) begin
                            y_d    = '0;
                            done_d = 1'b1;
                            if (!en_i) begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            y_d = y_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        x_d = x_q + CNT_WIDTH'(1);
                    end
                end else begin
                    cnt_d = cnt_q + PERIOD_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start: from idle, or seamless restart after the last pixel.
        if (en_i && (state_q == IDLE || done_d)) begin
            pm1_d = (pix_period_i == '0) ? '0
                  : pix_period_i - PERIOD_WIDTH'(1);
            wm1_d = (line_width_i == '0) ? '0
                  : line_width_i - CNT_WIDTH'(1);
            hm1_d = (frame_height_i == '0) ? '0
                  : frame_height_i - CNT_WIDTH'(1);
            pat_d = pattern_i;
            arg_d = pattern_arg_i;
            cnt_d = '0;
            x_d   = '0;
            y_d   = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pm1_q   <= '0;
            wm1_q   <= '0;
            hm1_q   <= '0;
            pat_q   <= '0;
            arg_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            do_q    <= '0;
            de_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pm1_q   <= pm1_d;
            wm1_q   <= wm1_d;
            hm1_q   <= hm1_d;
            pat_q   <= pat_d;
            arg_q   <= arg_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            do_q    <= do_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign vid.do_o    = do_q;
    assign vid.de_o    = de_q;
    assign vid.hs_o    = hs_q;
    assign vid.vs_o    = vs_q;
    assign busy_o      = busy_q;
    assign frame_cnt_o = fcnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: frame-level reference model, directed
// scenarios with literal expectations, and randomized configurations.
module tb_video_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  per;
    logic [11:0] wid;
    logic [11:0] hgt;
    logic [2:0]  pat;
    logic [7:0]  arg;
    logic        busy;
    logic [15:0] fcnt;

    always #5 clk = ~clk;

    video_pattern_gen_if #(.PIXEL_WIDTH(8)) vid ();

    video_pattern_gen #(
        .PIXEL_WIDTH(8),
        .CNT_WIDTH(12),
        .PERIOD_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en_i(en),
        .pix_period_i(per),
        .line_width_i(wid),
        .frame_height_i(hgt),
        .pattern_i(pat),
        .pattern_arg_i(arg),
        .vid(vid.master),
        .busy_o(busy),
        .frame_cnt_o(fcnt)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // A frame started at edge s emits pixel k at edge s+P*(k+1);
    // pixel k sits at x=k%W, y=k/W. Frame count bumps one edge
    // after the last pixel.
    bit          m_ok = 0;
    bit          m_run = 0;
    bit          m_pend = 0;
    int          m_t, m_P, m_W, m_H, m_pat;
    logic [7:0]  m_arg;
    logic        e_de, e_hs, e_vs, e_busy, e_rst;
    logic [7:0]  e_do;
    logic [15:0] e_fc;

    function automatic logic [7:0] pat_val(int p, logic [7:0] a,
                                           int x, int y);
        case (p)
            0: return 8'(x);
            1: return 8'(y);
            2: return (x == int'(a)) ? 8'hFF : 8'h00;
            3: return (((x >> a[3:0]) & 1) != 0) ? 8'h00 : 8'hFF;
            4: return (x == y) ? 8'hFF : 8'h00;
            5: return a;
            default: return 8'h00;
        endcase
    endfunction

    task automatic start_frame();
        m_P   = (per == 0) ? 1 : int'(per);
        m_W   = (wid == 0) ? 1 : int'(wid);
        m_H   = (hgt == 0) ? 1 : int'(hgt);
        m_pat = int'(pat);
        m_arg = arg;
        m_t   = 0;
        m_run = 1;
    endtask

    // Model advance at each active edge, using the inputs seen by the DUT.
    always @(posedge clk) begin
        int k, x, y;
        e_de  = 0;
        e_hs  = 0;
        e_vs  = 0;
        e_rst = 0;
        if (rst) begin
            m_ok   = 1;
            m_run  = 0;
            m_pend = 0;
            e_fc   = 0;
            e_busy = 0;
            e_do   = 0;
            e_rst  = 1;
        end else if (m_ok) begin
            if (m_pend) e_fc = e_fc + 16'd1;
            m_pend = 0;
            if (!m_run) begin
                if (en) begin
                    start_frame();
                    e_busy = 1;
                end
            end else begin
                m_t++;
                if (m_t % m_P == 0) begin
                    k    = m_t / m_P - 1;
                    x    = k % m_W;
                    y    = k / m_W;
                    e_de = 1;
                    e_hs = (x == 0);
                    e_vs = (k == 0);
                    e_do = pat_val(m_pat, m_arg, x, y);
                    if (k == m_W * m_H - 1) begin
                        m_pend = 1;
                        if (en) start_frame();
                        else begin
                            m_run  = 0;
                            e_busy = 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- compare + monitor ----------------
    int   cyc = 0;
    int   de_n, hs_n, vs_n;
    int   first_de_cyc, busy_rise_cyc;
    logic busy_p = 0;
    logic [7:0] cap[$];
    int         capc[$];
    logic       capv[$];

    always @(negedge clk) begin
        logic [7:0] ad, ed;
        cyc++;
        if (m_ok) begin
            ad = (e_de || e_rst) ? vid.do_o : 8'h00;
            ed = (e_de || e_rst) ? e_do : 8'h00;
            check("stream",
                  {vid.de_o, vid.hs_o, vid.vs_o, busy, fcnt, ad},
                  {e_de, e_hs, e_vs, e_busy, e_fc, ed});
        end
        if (vid.de_o === 1'b1) begin
            de_n++;
            cap.push_back(vid.do_o);
            capc.push_back(cyc);
            capv.push_back(vid.vs_o);
            if (first_de_cyc < 0) first_de_cyc = cyc;
        end
        if (vid.hs_o === 1'b1) hs_n++;
        if (vid.vs_o === 1'b1) vs_n++;
        if (busy === 1'b1 && busy_p !== 1'b1 && busy_rise_cyc < 0)
            busy_rise_cyc = cyc;
        busy_p = busy;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mon();
        de_n = 0;
        hs_n = 0;
        vs_n = 0;
        first_de_cyc  = -1;
        busy_rise_cyc = -1;
        cap.delete();
        capc.delete();
        capv.delete();
    endtask

    task automatic wait_idle(string name, int max);
        for (int i = 0; i < max && busy !== 1'b0; i++) tick();
        check(name, busy, 1'b0);
    endtask

    task automatic wait_de(string name, int n, int max);
        for (int i = 0; i < max && de_n < n; i++) tick();
        check(name, de_n >= n, 1'b1);
    endtask

    task automatic rand_cfg();
        per = 8'($urandom_range(0, 3));
        wid = 12'($urandom_range(0, 9));
        hgt = 12'($urandom_range(0, 4));
        pat = 3'($urandom_range(0, 7));
        arg = 8'($urandom);
        if (pat == 3'd2) arg = 8'($urandom_range(0, 9));
        if (pat == 3'd3) arg[3:0] = 4'($urandom_range(0, 11));
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int fc0, bad1, bad2, n0;
        rst = 1; en = 0; per = 0; wid = 0; hgt = 0; pat = 0; arg = 0;
        clr_mon();
        repeat (3) tick();
        check("rst_de", {vid.de_o, vid.hs_o, vid.vs_o}, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_fcnt", fcnt, 16'd0);
        check("rst_do", vid.do_o, 8'h00);
        rst = 0;
        tick();

        // 1: P=4, 24x3 h-gradient, single frame
        per = 4; wid = 24; hgt = 3; pat = 0; arg = 0; en = 1;
        clr_mon();
        tick();
        en = 0;
        wait_idle("t1_idle", 400);
        tick(); tick();
        check("t1_de_count", de_n, 72);
        check("t1_hs_count", hs_n, 3);
        check("t1_vs_count", vs_n, 1);
        check("t1_fcnt", fcnt, 16'd1);
        check("t1_latency", first_de_cyc - busy_rise_cyc, 4);
        check("t1_first_vs", capv[0], 1'b1);
        check("t1_gap", capc[1] - capc[0], 4);
        check("t1_do_23", cap[23], 8'd23);
        check("t1_do_24", cap[24], 8'd0);

        // 2: P=1, 5x2 diagonal, back-to-back repeated frames
        per = 1; wid = 5; hgt = 2; pat = 4; en = 1;
        clr_mon();
        repeat (30) tick();
        en = 0;
        wait_idle("t2_idle", 100);
        for (int i = 0; i < 10; i++)
            check("t2_do", cap[i], (i == 0 || i == 6) ? 8'hFF : 8'h00);
        check("t2_span", capc[9] - capc[0], 9);
        check("t2_seamless", capc[10] - capc[9], 1);
        check("t2_vs_again", capv[10], 1'b1);

        // 3: en dropped at pixel (3,1) of an 8x4 frame
        tick();
        fc0 = int'(fcnt);
        per = 2; wid = 8; hgt = 4; pat = 1; en = 1;
        clr_mon();
        wait_de("t3_reach", 12, 200);
        en = 0;
        wait_idle("t3_idle", 200);
        tick(); tick();
        check("t3_de_count", de_n, 32);
        check("t3_fcnt", fcnt, 16'(fc0 + 1));
        repeat (20) tick();
        check("t3_no_more_de", de_n, 32);

        // 4: pattern switched mid-frame takes effect next frame
        per = 2; wid = 6; hgt = 2; pat = 0; arg = 0; en = 1;
        clr_mon();
        wait_de("t4_mid", 3, 100);
        pat = 5; arg = 8'h5A;
        wait_de("t4_f2", 13, 200);
        en = 0;
        wait_idle("t4_idle", 200);
        bad1 = 0;
        bad2 = 0;
        for (int i = 0; i < 12; i++) if (cap[i] !== 8'(i % 6)) bad1++;
        for (int i = 12; i < 24; i++) if (cap[i] !== 8'h5A) bad2++;
        check("t4_f1_gradient", bad1, 0);
        check("t4_f2_solid", bad2, 0);
        check("t4_de_count", de_n, 24);

        // 5: reset mid-line
        per = 3; wid = 10; hgt = 3; pat = 0; en = 1;
        clr_mon();
        wait_de("t5_mid", 4, 100);
        rst = 1;
        tick();
        check("t5_rst_out", {vid.de_o, vid.hs_o, vid.vs_o, busy}, 4'b0000);
        check("t5_rst_fcnt", fcnt, 16'd0);
        check("t5_rst_do", vid.do_o, 8'h00);
        rst = 0;
        clr_mon();
        wait_de("t5_restart", 1, 100);
        check("t5_vs", capv[0], 1'b1);
        check("t5_do", cap[0], 8'h00);
        en = 0;
        wait_idle("t5_idle", 200);

        // Randomized configurations, enables, config churn, resets
        for (int it = 0; it < 30; it++) begin
            rand_cfg();
            en = 1;
            repeat ($urandom_range(20, 150)) begin
                tick();
                rst = 0;
                if ($urandom_range(0, 9) == 0) en = ~en;
                if ($urandom_range(0, 7) == 0) rand_cfg();
                if ($urandom_range(0, 199) == 0) rst = 1;
            end
        end
        rst = 0;
        en = 0;
        wait_idle("rand_idle", 500);

        // 6: zero geometry -> 1x1 at P=1, frame counter wraps
        rst = 1;
        tick();
        rst = 0;
        per = 0; wid = 0; hgt = 0; pat = 5; arg = 8'h33; en = 1;
        tick(); tick(); tick();
        check("t6_strobes", {vid.de_o, vid.hs_o, vid.vs_o}, 3'b111);
        check("t6_do", vid.do_o, 8'h33);
        n0 = int'(fcnt);
        tick();
        check("t6_fcnt_step", fcnt, 16'(n0 + 1));
        for (int i = 0; i < 70000 && fcnt !== 16'hFFFF; i++) tick();
        check("t6_reach_ffff", fcnt, 16'hFFFF);
        tick();
        check("t6_wrap", fcnt, 16'h0000);
        en = 0;
        repeat (3) tick();
        check("t6_stop", {vid.de_o, busy}, 2'b00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
